// File: rtl/branch_predictor_bht_pkg.sv
// Shared types and helpers for the branch history / target table.
// Counter encoding and sweep FSM states live here so the predictor and its counter agree.
package branch_predictor_bht_pkg;

    typedef enum logic [1:0] {
        BhtNnTaken = 2'b00,
        BhtNTaken  = 2'b01,
        BhtTaken   = 2'b10,
        BhtTTaken  = 2'b11
    } bht_state_e;

    typedef logic [0:0] bht_fsm_e;

    localparam bht_fsm_e BhtIdle  = 1'b0;
    localparam bht_fsm_e BhtClear = 1'b1;

    function automatic bht_state_e bht_next_state(input bht_state_e state, input logic taken);
        bht_state_e next;
        case (state)
            BhtNnTaken: next = taken ? BhtNTaken : BhtNnTaken;
            BhtNTaken:  next = taken ? BhtTaken  : BhtNnTaken;
            BhtTaken:   next = taken ? BhtTTaken : BhtNTaken;
            BhtTTaken:  next = taken ? BhtTTaken : BhtTaken;
            default:    next = state;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter.sv
// Two-bit saturating counter: next state for a resolved outcome plus the predict bit
// of the current state.
module bht_sat_counter
    import branch_predictor_bht_pkg::*;
(
    input  bht_state_e ctr_i,
    input  logic       taken_i,
    output bht_state_e ctr_o,
    output logic       predict_o
);

    assign ctr_o     = bht_next_state(ctr_i, taken_i);
    assign predict_o = ctr_i[1];

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history / target table: same-cycle IF prediction, EX training and
// mispredict redirect, plus a multi-cycle sweep that invalidates the table on flush.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        ex_update_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    input  logic        flush_i,
    output logic        busy_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    bht_state_e         ctr_q [ENTRIES];
    bht_state_e         ctr_d [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];
    logic [29:0]        tgt_d [ENTRIES];

    bht_fsm_e         fsm_q, fsm_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    bht_state_e       upd_ctr;
    logic             unused_upd_predict;
    logic             unused_if_pc_bits;

    assign busy_o = (fsm_q == BhtClear);

    assign if_idx = if_pc_i[IDX_W+1:2];
    assign if_tag = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = ex_pc_i[IDX_W+1:2];
    assign ex_tag = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    assign unused_if_pc_bits = ^{if_pc_i[1:0], if_pc_i[31:IDX_W+TAG_W+2]};

    // Predictions are suppressed while the sweep has the table partially cleared.
    assign if_hit        = if_valid_i & valid_q[if_idx] & (tag_q[if_idx] == if_tag) & ~busy_o;
    assign pred_taken_o  = if_hit & ctr_q[if_idx][1];
    assign pred_target_o = pred_taken_o ? {tgt_q[if_idx], 2'b00} : 32'h0;

    assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

    bht_sat_counter u_upd_ctr (
        .ctr_i     (ctr_q[ex_idx]),
        .taken_i   (ex_taken_i),
        .ctr_o     (upd_ctr),
        .predict_o (unused_upd_predict)
    );

    // Redirect logic is purely combinational and stays live during the sweep.
    assign mispredict_o  = rst_n & ex_update_i &
                           ((ex_taken_i != ex_pred_taken_i) |
                            (ex_taken_i & (ex_target_i != ex_pred_target_i)));
    assign redirect_pc_o = !rst_n     ? 32'h0 :
                           ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;

    always_comb begin
        valid_d     = valid_q;
        ctr_d       = ctr_q;
        tag_d       = tag_q;
        tgt_d       = tgt_q;
        fsm_d       = fsm_q;
        sweep_idx_d = sweep_idx_q;
        case (fsm_q)
            BhtIdle: begin
                if (flush_i) begin
                    fsm_d       = BhtClear;
                    sweep_idx_d = '0;
                end else if (ex_update_i) begin
                    if (ex_hit) begin
                        ctr_d[ex_idx] = upd_ctr;
                        if (ex_taken_i) begin
                            tgt_d[ex_idx] = ex_target_i[31:2];
                        end
                    end else if (ex_taken_i) begin
                        valid_d[ex_idx] = 1'b1;
                        tag_d[ex_idx]   = ex_tag;
                        ctr_d[ex_idx]   = BhtTaken;
                        tgt_d[ex_idx]   = ex_target_i[31:2];
                    end
                end
            end
            BhtClear: begin
                valid_d[sweep_idx_q] = 1'b0;
                if (flush_i) begin
                    sweep_idx_d = '0;
                end else if (sweep_idx_q == LastIdx) begin
                    fsm_d       = BhtIdle;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDX_W'(1);
                end
            end
            default: fsm_d = BhtIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            fsm_q       <= BhtIdle;
            sweep_idx_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BhtNTaken;
            end
        end else begin
            valid_q     <= valid_d;
            fsm_q       <= fsm_d;
            sweep_idx_q <= sweep_idx_d;
            ctr_q       <= ctr_d;
        end
    end

    // Tags and targets are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: training, saturation, aliasing, redirect,
// and flush sweep with restart and mid-sweep reset.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        ex_update_i;
    logic [31:0] ex_pc_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic        flush_i;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .ENTRIES (64),
        .TAG_W   (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid_i       (if_valid_i),
        .if_pc_i          (if_pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .ex_update_i      (ex_update_i),
        .ex_pc_i          (ex_pc_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .mispredict_o     (mispredict_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_i          (flush_i),
        .busy_o           (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        ex_update_i = 1'b1;
        ex_pc_i     = pc;
        ex_taken_i  = taken;
        ex_target_i = tgt;
        tick();
        ex_update_i = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken,
                          input logic [31:0] exp_tgt);
        if_valid_i = 1'b1;
        if_pc_i    = pc;
        #1;
        check_eq({tag, "_taken"}, {31'h0, pred_taken_o}, {31'h0, exp_taken});
        check_eq({tag, "_target"}, pred_target_o, exp_tgt);
    endtask

    task automatic train4;
        for (int i = 0; i < 4; i++) begin
            update(32'h100 + 32'(4 * i), 1'b1, 32'h400 + 32'(64 * i));
        end
        lookup("train4", 32'h104, 1'b1, 32'h440);
    endtask

    // Flush, then count busy cycles; optional re-flush at cycle restart_at.
    task automatic run_sweep(input int restart_at, output int cycles);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        cycles  = 0;
        while (busy_o && cycles < 300) begin
            if (cycles == restart_at) flush_i = 1'b1;
            if (cycles == 5) begin
                lookup("sweep_forced_nt", 32'h10C, 1'b0, 32'h0);
                ex_update_i     = 1'b1;
                ex_pc_i         = 32'h110;
                ex_taken_i      = 1'b1;
                ex_target_i     = 32'h700;
                ex_pred_taken_i = 1'b0;
                #1;
                check_eq("sweep_mispredict", {31'h0, mispredict_o}, 32'h1);
            end
            tick();
            flush_i     = 1'b0;
            ex_update_i = 1'b0;
            cycles++;
        end
    endtask

    task automatic check_all_miss(input string tag);
        for (int i = 0; i < 5; i++) begin
            lookup(tag, 32'h100 + 32'(4 * i), 1'b0, 32'h0);
        end
    endtask

    initial begin
        int cycles;
        rst_n            = 1'b0;
        if_valid_i       = 1'b1;
        if_pc_i          = 32'h100;
        ex_update_i      = 1'b1;
        ex_pc_i          = 32'h500;
        ex_taken_i       = 1'b1;
        ex_target_i      = 32'h300;
        ex_pred_taken_i  = 1'b0;
        ex_pred_target_i = 32'h0;
        flush_i          = 1'b0;
        #2;
        check_eq("rst_mispredict", {31'h0, mispredict_o}, 32'h0);
        check_eq("rst_redirect", redirect_pc_o, 32'h0);
        check_eq("rst_busy", {31'h0, busy_o}, 32'h0);
        ex_update_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state lookup
        lookup("t1", 32'h100, 1'b0, 32'h0);
        check_eq("t1_busy", {31'h0, busy_o}, 32'h0);

        // Training: allocate at ctr=10, then saturate at 11
        update(32'h100, 1'b1, 32'h200);
        lookup("t2_alloc", 32'h100, 1'b1, 32'h200);
        if_valid_i = 1'b0;
        #1;
        check_eq("t2_ifvalid_low", {31'h0, pred_taken_o}, 32'h0);
        repeat (3) update(32'h100, 1'b1, 32'h200);
        lookup("t2_sat", 32'h100, 1'b1, 32'h200);

        // 11 -> 10 -> 01 -> 00 -> 00, then +1 -> 01 proves no underflow
        update(32'h100, 1'b0, 32'h0);
        lookup("t3_nt1", 32'h100, 1'b1, 32'h200);
        update(32'h100, 1'b0, 32'h0);
        lookup("t3_nt2", 32'h100, 1'b0, 32'h0);
        update(32'h100, 1'b0, 32'h0);
        update(32'h100, 1'b0, 32'h0);
        lookup("t3_nt4", 32'h100, 1'b0, 32'h0);
        update(32'h100, 1'b1, 32'h200);
        lookup("t3_no_underflow", 32'h100, 1'b0, 32'h0);

        // Aliasing at same index, different tag
        update(32'h100, 1'b1, 32'h200);
        lookup("t4_trained", 32'h100, 1'b1, 32'h200);
        lookup("t4_alias_miss", 32'h200, 1'b0, 32'h0);
        update(32'h200, 1'b1, 32'h600);
        lookup("t4_alias_alloc", 32'h200, 1'b1, 32'h600);
        lookup("t4_orig_miss", 32'h100, 1'b0, 32'h0);

        // Mispredict / redirect (combinational, not clocked in)
        ex_update_i      = 1'b1;
        ex_pc_i          = 32'h500;
        ex_taken_i       = 1'b1;
        ex_target_i      = 32'h300;
        ex_pred_taken_i  = 1'b1;
        ex_pred_target_i = 32'h200;
        #1;
        check_eq("t5_tgt_mispredict", {31'h0, mispredict_o}, 32'h1);
        check_eq("t5_tgt_redirect", redirect_pc_o, 32'h300);
        ex_pred_target_i = 32'h300;
        #1;
        check_eq("t5_correct", {31'h0, mispredict_o}, 32'h0);
        ex_pc_i    = 32'hFFFF_FFFC;
        ex_taken_i = 1'b0;
        #1;
        check_eq("t5_nt_mispredict", {31'h0, mispredict_o}, 32'h1);
        check_eq("t5_wrap_redirect", redirect_pc_o, 32'h0);
        ex_update_i = 1'b0;
        #1;
        check_eq("t5_no_update", {31'h0, mispredict_o}, 32'h0);
        ex_pred_taken_i = 1'b0;
        ex_taken_i      = 1'b0;

        // Flush sweep
        train4();
        run_sweep(-1, cycles);
        check_eq("t6_sweep_len", 32'(cycles), 32'd64);
        check_all_miss("t6_after");

        // Re-flush at cycle 30 restarts the sweep
        train4();
        run_sweep(30, cycles);
        check_eq("t6_restart_len", 32'(cycles), 32'd95);
        check_all_miss("t6_restart_after");

        // Reset mid-sweep
        train4();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (10) tick();
        check_eq("t6_busy_mid", {31'h0, busy_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy", {31'h0, busy_o}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_eq("t6_post_rst_busy", {31'h0, busy_o}, 32'h0);
        check_all_miss("t6_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
